// File: rtl/float_mul_pipe_hs_if.sv
// Handshake bundle between FPU issue, the FP multiplier and the writeback arbiter.
// The master drives operands and out_ready, and the slave (the multiplier) returns results.
interface float_mul_pipe_hs_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [1:0]       rm;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     s;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, rm, in_tag, out_ready,
        input  in_ready, out_valid, s, out_tag, flags
    );

    modport slave (
        input  in_valid, a, b, rm, in_tag, out_ready,
        output in_ready, out_valid, s, out_tag, flags
    );
endinterface

// File: rtl/float_mul_pipe_hs.sv
// Three-stage IEEE-754 multiplier (unpack / multiply / normalise+round) with
// valid/ready flow control, bubble collapse, flush and {NV,OF,UF,NX} flags.
module float_mul_pipe_hs #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input logic clk,
    input logic rst,
    input logic flush,
    float_mul_pipe_hs_if.slave io
);
    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int SW   = FRAC_W + 1;
    localparam int PW   = 2 * SW;
    localparam int EW   = EXP_W + 2;
    localparam int XW   = EXP_W + 4;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic [SW-1:0]    sa;
        logic [SW-1:0]    sb;
        logic [EW-1:0]    exp;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic             nv;
        logic [1:0]       rm;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [PW-1:0]    prod;
        logic [EW-1:0]    exp;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic             nv;
        logic [1:0]       rm;
        logic [TAG_W-1:0] tag;
    } s2_t;

    logic v1, v2, ov;
    logic ld1, ld2, ld3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic [W-1:0]     s_q, res;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       fl_q, fl;

    // Each stage advances when empty or when its successor advances.
    assign ld3 = !ov || io.out_ready;
    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;

    assign io.in_ready  = ld1;
    assign io.out_valid = ov;
    assign io.s         = s_q;
    assign io.out_tag   = tag_q;
    assign io.flags     = fl_q;

    // ---------------- stage 1: unpack and classify ----------------
    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff;
    logic [FRAC_W-1:0] fa, fb;
    logic za, zb, ia, ib, na, nb, sna, snb, zxi;

    always_comb begin
        ea  = io.a[W-2:FRAC_W];
        eb  = io.b[W-2:FRAC_W];
        fa  = io.a[FRAC_W-1:0];
        fb  = io.b[FRAC_W-1:0];
        za  = (ea == '0) && (fa == '0);
        zb  = (eb == '0) && (fb == '0);
        ia  = (ea == EXP_ONES) && (fa == '0);
        ib  = (eb == EXP_ONES) && (fb == '0);
        na  = (ea == EXP_ONES) && (fa != '0);
        nb  = (eb == EXP_ONES) && (fb != '0);
        sna = na && !fa[FRAC_W-1];
        snb = nb && !fb[FRAC_W-1];
        zxi = (za && ib) || (ia && zb);
        // Denormals behave as exponent 1 with a zero hidden bit.
        ea_eff = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff = (eb == '0) ? EXP_W'(1) : eb;

        s1_d          = '0;
        s1_d.sign     = io.a[W-1] ^ io.b[W-1];
        s1_d.sa       = {ea != '0, fa};
        s1_d.sb       = {eb != '0, fb};
        s1_d.exp      = EW'(ea_eff) + EW'(eb_eff) - EW'(BIAS);
        s1_d.rm       = io.rm;
        s1_d.tag      = io.in_tag;
        if (na || nb || zxi) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = QNAN;
            s1_d.nv       = sna || snb || zxi;
        end else if (ia || ib) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {s1_d.sign, EXP_ONES, {FRAC_W{1'b0}}};
        end else if (za || zb) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {s1_d.sign, {(W-1){1'b0}}};
        end
    end

    // ---------------- stage 2: significand product ----------------
    always_comb begin
        s2_d          = '0;
        s2_d.sign     = s1_q.sign;
        s2_d.prod     = PW'(s1_q.sa) * PW'(s1_q.sb);
        s2_d.exp      = s1_q.exp;
        s2_d.spec     = s1_q.spec;
        s2_d.spec_res = s1_q.spec_res;
        s2_d.nv       = s1_q.nv;
        s2_d.rm       = s1_q.rm;
        s2_d.tag      = s1_q.tag;
    end

    // ---------------- stage 3: normalise, denormalise, round ----------------
    function automatic logic [XW-1:0] lzc(input logic [PW-1:0] p);
        logic [XW-1:0] n;
        n = XW'(PW);
        for (int i = 0; i < PW; i++)
            if (p[i]) n = XW'(PW - 1 - i);
        return n;
    endfunction

    logic [XW-1:0] lz, e_norm, sh, e_eff, e_fin;
    logic [PW-1:0] p_norm, p_den;
    logic [SW-1:0] mant, mant_f;
    logic [SW:0]   mant_r;
    logic tiny, lost, guard, sticky, inexact, inc, ovf, to_inf;

    always_comb begin
        lz     = lzc(s2_q.prod);
        // Biased exponent of the product once its leading one is at the top bit.
        e_norm = {{(XW-EW){s2_q.exp[EW-1]}}, s2_q.exp} + XW'(1) - lz;
        p_norm = s2_q.prod << lz;
        tiny   = e_norm[XW-1] || (e_norm == '0);
        sh     = tiny ? (XW'(1) - e_norm) : '0;
        if (sh > XW'(PW)) sh = XW'(PW);
        p_den   = p_norm >> sh;
        lost    = |(p_norm & ~({PW{1'b1}} << sh));
        e_eff   = tiny ? XW'(1) : e_norm;
        mant    = p_den[PW-1 -: SW];
        guard   = p_den[FRAC_W];
        sticky  = (|p_den[FRAC_W-1:0]) || lost;
        inexact = guard || sticky;

        case (s2_q.rm)
            2'd0:    inc = guard && (sticky || mant[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !s2_q.sign && inexact;
            default: inc = s2_q.sign && inexact;
        endcase

        mant_r = {1'b0, mant} + (SW+1)'(inc);
        if (mant_r[SW]) begin
            mant_f = mant_r[SW:1];
            e_fin  = e_eff + XW'(1);
        end else begin
            mant_f = mant_r[SW-1:0];
            e_fin  = e_eff;
        end

        ovf    = mant_f[FRAC_W] && (e_fin >= XW'(EXP_ONES));
        to_inf = (s2_q.rm == 2'd0) || (s2_q.rm == 2'd2 && !s2_q.sign) ||
                 (s2_q.rm == 2'd3 && s2_q.sign);

        if (s2_q.spec) begin
            res = s2_q.spec_res;
            fl  = {s2_q.nv, 3'b000};
        end else if (ovf) begin
            res = to_inf ? {s2_q.sign, EXP_ONES, {FRAC_W{1'b0}}}
                         : {s2_q.sign, EXP_ONES - EXP_W'(1), {FRAC_W{1'b1}}};
            fl  = 4'b0101;
        end else begin
            // A clear hidden bit after rounding means a denormal (or zero) encoding.
            res = {s2_q.sign, mant_f[FRAC_W] ? e_fin[EXP_W-1:0] : {EXP_W{1'b0}},
                   mant_f[FRAC_W-1:0]};
            fl  = {2'b00, tiny && inexact, inexact};
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            ov <= 1'b0;
        end else begin
            if (ld1) v1 <= io.in_valid;
            if (ld2) v2 <= v1;
            if (ld3) ov <= v2;
        end
    end

    always_ff @(posedge clk) begin
        if (ld1 && io.in_valid) s1_q <= s1_d;
        if (ld2 && v1)          s2_q <= s2_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            tag_q <= '0;
            fl_q  <= '0;
        end else if (ld3 && v2) begin
            s_q   <= res;
            tag_q <= s2_q.tag;
            fl_q  <= fl;
        end
    end
endmodule

// File: tb/tb_float_mul_pipe_hs.sv
// Directed and randomized checks of float_mul_pipe_hs (binary32) against an
// exact-quantum rounding model, with a scoreboard for ordering under backpressure.
module tb_float_mul_pipe_hs;
    localparam int EXP_W = 8, FRAC_W = 23, TAG_W = 4;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    float_mul_pipe_hs_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) io ();
    float_mul_pipe_hs #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .io(io)
    );

    typedef struct packed { logic [31:0] s; logic [3:0] f; logic [3:0] tag; } exp_t;
    exp_t sb[$];

    int vectors = 0, errors = 0;
    int occ = 0, received = 0;
    bit have_op = 0, prev_stall = 0;
    logic [31:0] pa, pb, prev_s;
    logic [1:0]  prm;
    logic [3:0]  ptag, prev_tag, prev_fl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Exact product M*2^E rounded to the quantum of the destination binade.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
        int ea, eb, xa, xb, e, k, q, sh, be;
        logic sign, na, nb, nv, zxi, rem_nz, above, tie, inc, tiny, to_inf;
        longint unsigned ma, mb, m, r, rem, half;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        sign = a[31] ^ b[31];
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        zxi = ((a[30:0] == 0) && (b[30:0] == 31'h7F800000)) ||
              ((b[30:0] == 0) && (a[30:0] == 31'h7F800000));
        nv = (na && !a[22]) || (nb && !b[22]) || zxi;
        if (na || nb || zxi) return {nv, 3'b000, 32'h7FC00000};
        if (ea == 255 || eb == 255) return {4'b0000, sign, 8'hFF, 23'h0};
        if (a[30:0] == 0 || b[30:0] == 0) return {4'b0000, sign, 31'h0};
        ma = {41'h0, ea != 0, a[22:0]};
        mb = {41'h0, eb != 0, b[22:0]};
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        m = ma * mb;
        e = xa + xb - 254 - 46;
        k = 0;
        for (int i = 0; i < 48; i++) if (m[i]) k = i;
        q = k + e - 23;
        if (q < -149) q = -149;
        sh = q - e;
        above = 0; tie = 0;
        if (sh <= 0) begin
            r = m << (-sh); rem_nz = 0;
        end else if (sh > 60) begin
            r = 0; rem_nz = 1;
        end else begin
            r = m >> sh;
            rem = m - (r << sh);
            half = 64'd1 << (sh - 1);
            rem_nz = (rem != 0); above = (rem > half); tie = (rem == half);
        end
        case (rm)
            2'd0: inc = above || (tie && r[0]);
            2'd1: inc = 0;
            2'd2: inc = !sign && rem_nz;
            default: inc = sign && rem_nz;
        endcase
        r = r + 64'(inc);
        if (r == (64'd1 << 24)) begin r = 64'd1 << 23; q++; end
        tiny = (k + e) < -126;
        if (r < (64'd1 << 23)) return {2'b00, tiny && rem_nz, rem_nz, sign, 8'h00, r[22:0]};
        be = q + 150;
        if (be >= 255) begin
            to_inf = (rm == 0) || (rm == 2 && !sign) || (rm == 3 && sign);
            return to_inf ? {4'b0101, sign, 8'hFF, 23'h0} : {4'b0101, sign, 8'hFE, 23'h7FFFFF};
        end
        return {2'b00, tiny && rem_nz, rem_nz, sign, be[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[30:23] = 8'h00;
            1: r[30:23] = 8'hFF;
            2: begin r[30:23] = 8'($urandom_range(0, 1) * 255); r[22:0] = 23'h0; end
            3: r[30:23] = 8'($urandom_range(100, 150));
            4: r[30:23] = 8'($urandom_range(190, 254));
            5: r[30:23] = 8'($urandom_range(1, 40));
            default: ;
        endcase
        return r;
    endfunction

    // One clock of handshake traffic; inputs applied at negedge, sampled 1 later.
    task automatic cycle(input bit ordy);
        bit in_fire, out_fire;
        exp_t e;
        io.in_valid  = have_op;
        io.a = pa; io.b = pb; io.rm = prm; io.in_tag = ptag;
        io.out_ready = ordy;
        #1;
        chk("in_ready", 64'(io.in_ready), 64'((occ < 3) || ordy));
        if (prev_stall) begin
            chk("hold_s", 64'(io.s), 64'(prev_s));
            chk("hold_tag", 64'(io.out_tag), 64'(prev_tag));
            chk("hold_flags", 64'(io.flags), 64'(prev_fl));
        end
        in_fire  = have_op && io.in_ready;
        out_fire = io.out_valid && ordy;
        if (out_fire) begin
            chk("out_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                received++;
                chk("s", 64'(io.s), 64'(e.s));
                chk("tag", 64'(io.out_tag), 64'(e.tag));
                chk("flags", 64'(io.flags), 64'(e.f));
            end
        end
        prev_stall = io.out_valid && !ordy;
        prev_s = io.s; prev_tag = io.out_tag; prev_fl = io.flags;
        if (in_fire) begin
            logic [35:0] m;
            m = ref_mul(pa, pb, prm);
            sb.push_back('{s: m[31:0], f: m[35:32], tag: ptag});
            have_op = 0;
        end
        occ = occ + int'(in_fire) - int'(out_fire);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm, input logic [3:0] tag);
        pa = a; pb = b; prm = rm; ptag = tag; have_op = 1;
    endtask

    // Single op into an empty pipe; the result register loads on the third edge
    // counting the accepting one.
    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] rm, input logic [3:0] tag,
                            input logic [31:0] es, input logic [3:0] ef);
        int n;
        io.in_valid = 1; io.a = a; io.b = b; io.rm = rm; io.in_tag = tag;
        io.out_ready = 1;
        @(posedge clk); @(negedge clk);
        io.in_valid = 0;
        n = 1;
        while (!io.out_valid && n < 8) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'(3));
        chk({nm, "_s"}, 64'(io.s), 64'(es));
        chk({nm, "_flags"}, 64'(io.flags), 64'(ef));
        chk({nm, "_tag"}, 64'(io.out_tag), 64'(tag));
        @(posedge clk); @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || occ != 0) && n < 60) begin
            cycle(1);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst = 1; flush = 0;
        io.in_valid = 0; io.a = '0; io.b = '0; io.rm = '0; io.in_tag = '0;
        io.out_ready = 1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_out_valid", 64'(io.out_valid), 64'(0));
        chk("rst_s", 64'(io.s), 64'(0));
        chk("rst_tag", 64'(io.out_tag), 64'(0));
        chk("rst_flags", 64'(io.flags), 64'(0));
        rst = 0;
        #1;
        chk("rst_in_ready", 64'(io.in_ready), 64'(1));
        @(negedge clk);

        directed("basic", 32'h3FC00000, 32'h40000000, 2'd0, 4'h1, 32'h40400000, 4'b0000);
        directed("rnd_rn", 32'h3F800001, 32'h3F800001, 2'd0, 4'h2, 32'h3F800002, 4'b0001);
        directed("rnd_rz", 32'h3F800001, 32'h3F800001, 2'd1, 4'h3, 32'h3F800002, 4'b0001);
        directed("rnd_rp", 32'h3F800001, 32'h3F800001, 2'd2, 4'h4, 32'h3F800003, 4'b0001);
        directed("rnd_rm", 32'h3F800001, 32'h3F800001, 2'd3, 4'h5, 32'h3F800002, 4'b0001);
        directed("inf_x_0", 32'h7F800000, 32'h00000000, 2'd0, 4'h6, 32'h7FC00000, 4'b1000);
        directed("ovf_rn", 32'h7F7FFFFF, 32'h40000000, 2'd0, 4'h7, 32'h7F800000, 4'b0101);
        directed("ovf_rz", 32'h7F7FFFFF, 32'h40000000, 2'd1, 4'h8, 32'h7F7FFFFF, 4'b0101);
        directed("ovf_rp_neg", 32'hFF7FFFFF, 32'h40000000, 2'd2, 4'h9, 32'hFF7FFFFF, 4'b0101);
        directed("den_half", 32'h00800000, 32'h3F000000, 2'd0, 4'hA, 32'h00400000, 4'b0000);
        directed("den_uf", 32'h00000001, 32'h3F000000, 2'd0, 4'hB, 32'h00000000, 4'b0011);
        directed("den_exact", 32'h00000003, 32'h3F800000, 2'd0, 4'hC, 32'h00000003, 4'b0000);

        // Backpressure: six ops, output stalled for cycles 2..7.
        begin
            int nxt = 0, cyc = 0;
            received = 0; prev_stall = 0;
            while ((nxt < 6 || have_op || sb.size() != 0) && cyc < 80) begin
                bit ordy;
                if (!have_op && nxt < 6) begin
                    load_op(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 4'(nxt));
                    nxt++;
                end
                if (cyc >= 2 && cyc <= 7) ordy = 0;
                else if (cyc < 2) ordy = 1;
                else ordy = 1'($urandom_range(0, 1));
                cycle(ordy);
                cyc++;
            end
            chk("bp_received", 64'(received), 64'(6));
        end

        // Random traffic with random backpressure.
        begin
            int cnt = 0;
            for (int c = 0; c < 500; c++) begin
                if (!have_op && $urandom_range(0, 3) != 0) begin
                    load_op(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 4'(cnt));
                    cnt++;
                end
                cycle($urandom_range(0, 3) != 0);
            end
            have_op = 0;
            drain();
        end

        // Flush with three ops held and a fourth presented.
        for (int i = 0; i < 3; i++) begin
            load_op(32'h3FC00000, 32'h40000000, 2'd0, 4'(i + 1));
            cycle(0);
        end
        flush = 1;
        io.in_valid = 1; io.a = 32'h40000000; io.b = 32'h40000000; io.in_tag = 4'hF;
        io.out_ready = 0;
        @(posedge clk); @(negedge clk);
        flush = 0; io.in_valid = 0;
        sb.delete(); occ = 0; prev_stall = 0;
        io.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("flush_quiet", 64'(io.out_valid), 64'(0));
            @(posedge clk); @(negedge clk);
        end
        directed("post_flush", 32'h40400000, 32'h40000000, 2'd0, 4'h6, 32'h40C00000, 4'b0000);

        // Same sequence with reset.
        for (int i = 0; i < 3; i++) begin
            load_op(32'h3FC00000, 32'h40000000, 2'd0, 4'(i + 1));
            cycle(0);
        end
        rst = 1;
        io.in_valid = 1; io.a = 32'h40000000; io.b = 32'h40000000; io.in_tag = 4'hF;
        io.out_ready = 0;
        @(posedge clk); @(negedge clk);
        chk("rst2_out_valid", 64'(io.out_valid), 64'(0));
        chk("rst2_s", 64'(io.s), 64'(0));
        chk("rst2_tag", 64'(io.out_tag), 64'(0));
        chk("rst2_flags", 64'(io.flags), 64'(0));
        rst = 0; io.in_valid = 0;
        sb.delete(); occ = 0; prev_stall = 0;
        io.out_ready = 1;
        #1;
        chk("rst2_in_ready", 64'(io.in_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst2_quiet", 64'(io.out_valid), 64'(0));
        end
        directed("post_rst", 32'hC0000000, 32'h3FC00000, 2'd0, 4'h3, 32'hC0400000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
